// File: rtl/anti_theft_controller_if.sv
// Timer handshake between the anti-theft sequencer and the shared 1 Hz countdown timer.
// The controller owns startTimer/value; the timer owns expired and its 1 Hz square wave.
interface anti_theft_controller_if;
    logic       startTimer;
    logic [3:0] value;
    logic       expired;
    logic       clock1Hz;

    modport master (
        output startTimer,
        output value,
        input  expired,
        input  clock1Hz
    );

    modport slave (
        input  startTimer,
        input  value,
        output expired,
        output clock1Hz
    );
endinterface

// File: rtl/anti_theft_controller.sv
// Anti-theft sequencer: arm/trigger/alarm FSM, programmable countdown delays,
// registered siren and status-LED outputs.
module anti_theft_controller #(
    parameter logic [3:0] T_ARM_DELAY       = 4'd6,
    parameter logic [3:0] T_DRIVER_DELAY    = 4'd8,
    parameter logic [3:0] T_PASSENGER_DELAY = 4'd15,
    parameter logic [3:0] T_ALARM_ON        = 4'd10
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            ignition,
    input  logic                            driverDoor,
    input  logic                            passengerDoor,
    input  logic                            reprogram,
    input  logic [1:0]                      timeParamSel,
    input  logic [3:0]                      timeValue,
    anti_theft_controller_if.master         tmr,
    output logic                            siren,
    output logic                            statusIndicator,
    output logic [2:0]                      state
);

    typedef enum logic [2:0] {
        ARMED          = 3'd0,
        TRIGGERED      = 3'd1,
        SIREN          = 3'd2,
        SIREN_HOLD     = 3'd3,
        DIS_IGN        = 3'd4,
        DIS_WAIT_OPEN  = 3'd5,
        DIS_WAIT_CLOSE = 3'd6,
        ARM_DELAY      = 3'd7
    } state_t;

    localparam logic [1:0] SEL_ARM    = 2'd0;
    localparam logic [1:0] SEL_DRIVER = 2'd1;
    localparam logic [1:0] SEL_PASS   = 2'd2;
    localparam logic [1:0] SEL_ALARM  = 2'd3;

    state_t     state_q, state_d;
    logic       start_q, start_d;
    logic [3:0] value_q, value_d;
    logic       siren_q, siren_d;
    logic       led_q, led_d;
    logic       live_q, live_d;
    logic [3:0] param_q [0:3];
    logic [3:0] param_d [0:3];

    logic       load;
    logic [1:0] load_sel;
    logic       expiry_ok;
    logic       any_door;

    // An expiry only counts for the countdown this state loaded, once its start pulse is gone.
    assign expiry_ok = live_q && !start_q && tmr.expired;
    assign any_door  = driverDoor || passengerDoor;

    always_comb begin
        param_d = param_q;
        if (reprogram) begin
            param_d[timeParamSel] = timeValue;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_sel = SEL_ARM;
        if (reprogram) begin
            state_d = ARMED;
        end else if (ignition && state_q != ARMED) begin
            state_d = DIS_IGN;
        end else begin
            case (state_q)
                ARMED: begin
                    if (driverDoor) begin
                        state_d  = TRIGGERED;
                        load     = 1'b1;
                        load_sel = SEL_DRIVER;
                    end else if (passengerDoor) begin
                        state_d  = TRIGGERED;
                        load     = 1'b1;
                        load_sel = SEL_PASS;
                    end
                end
                TRIGGERED: begin
                    if (expiry_ok) state_d = SIREN;
                end
                SIREN: begin
                    if (!any_door) begin
                        state_d  = SIREN_HOLD;
                        load     = 1'b1;
                        load_sel = SEL_ALARM;
                    end
                end
                SIREN_HOLD: begin
                    if (any_door)       state_d = SIREN;
                    else if (expiry_ok) state_d = ARMED;
                end
                DIS_IGN: begin
                    state_d = DIS_WAIT_OPEN;
                end
                DIS_WAIT_OPEN: begin
                    if (driverDoor) state_d = DIS_WAIT_CLOSE;
                end
                DIS_WAIT_CLOSE: begin
                    if (!driverDoor) begin
                        state_d  = ARM_DELAY;
                        load     = 1'b1;
                        load_sel = SEL_ARM;
                    end
                end
                ARM_DELAY: begin
                    if (driverDoor)     state_d = DIS_WAIT_CLOSE;
                    else if (expiry_ok) state_d = ARMED;
                end
                default: state_d = ARMED;
            endcase
        end
    end

    always_comb begin
        start_d = load;
        value_d = load ? param_q[load_sel] : value_q;
        // Any move out of the loading state kills the countdown; re-entry always reloads.
        if (load)                                live_d = 1'b1;
        else if (reprogram || state_d != state_q) live_d = 1'b0;
        else                                     live_d = live_q;
        siren_d = (state_d == SIREN) || (state_d == SIREN_HOLD);
        case (state_d)
            ARMED:                        led_d = tmr.clock1Hz;
            TRIGGERED, SIREN, SIREN_HOLD: led_d = 1'b1;
            default:                      led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ARMED;
            start_q    <= 1'b0;
            value_q    <= 4'd0;
            siren_q    <= 1'b0;
            led_q      <= 1'b0;
            live_q     <= 1'b0;
            param_q[0] <= T_ARM_DELAY;
            param_q[1] <= T_DRIVER_DELAY;
            param_q[2] <= T_PASSENGER_DELAY;
            param_q[3] <= T_ALARM_ON;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            value_q    <= value_d;
            siren_q    <= siren_d;
            led_q      <= led_d;
            live_q     <= live_d;
            param_q[0] <= param_d[0];
            param_q[1] <= param_d[1];
            param_q[2] <= param_d[2];
            param_q[3] <= param_d[3];
        end
    end

    assign tmr.startTimer  = start_q;
    assign tmr.value       = value_q;
    assign siren           = siren_q;
    assign statusIndicator = led_q;
    assign state           = state_q;

endmodule

// File: doc/anti_theft_controller.md
# anti_theft_controller

Top-level sequencer for the anti-theft system. It reads the ignition and door sensors and runs the arm/trigger/alarm state machine. It drives the shared 1 Hz countdown timer (startTimer/value/expired), choosing one of four programmable delay parameters for each countdown, and it produces the siren and status-LED outputs.

## Interface
- T_ARM_DELAY, 6: seconds from driver-door close to re-arm.
- T_DRIVER_DELAY, 8: seconds of grace after the driver door opens while armed.
- T_PASSENGER_DELAY, 15: seconds of grace after a passenger door opens while armed.
- T_ALARM_ON, 10: seconds the siren stays on after all doors close.

Ports:
- clock  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high.
- ignition  in  1  1 = ignition on.
- driverDoor  in  1  1 = driver door open.
- passengerDoor  in  1  1 = a passenger door open.
- reprogram  in  1  one-cycle strobe: write timeValue into the parameter selected by timeParamSel.
- timeParamSel  in  2  parameter select: 0 = ARM_DELAY, 1 = DRIVER_DELAY, 2 = PASSENGER_DELAY, 3 = ALARM_ON.
- timeValue  in  4  new parameter value in seconds.
- expired  in  1  timer expiry pulse.
- clock1Hz  in  1  timer's 1 Hz square wave, used for LED blink.
- startTimer  out  1  one-cycle timer load/start pulse.
- value  out  4  countdown length presented to the timer.
- siren  out  1  alarm output.
- statusIndicator  out  1  status LED.
- state  out  3  current state code, for debug.

## Operation
- Parameter registers: four 4-bit registers, initialised to the parameter defaults on reset. A reprogram write stores timeValue verbatim, including 0.
- State codes:
  - ARMED = 0
  - TRIGGERED = 1
  - SIREN = 2
  - SIREN_HOLD = 3
  - DIS_IGN = 4
  - DIS_WAIT_OPEN = 5
  - DIS_WAIT_CLOSE = 6
  - ARM_DELAY = 7
- Priority each cycle: reset > reprogram > ignition > door/expired conditions.
- reprogram: the register is written and the FSM goes to ARMED from any state. startTimer is not pulsed. A new value takes effect at the next load of that parameter.
- Transitions:
  - ARMED: driverDoor -> TRIGGERED, load DRIVER. Otherwise passengerDoor -> TRIGGERED, load PASSENGER. Both doors in the same cycle -> DRIVER. Ignition alone is ignored.
  - TRIGGERED: ignition -> DIS_IGN. expired -> SIREN.
  - SIREN: ignition -> DIS_IGN. Both doors closed -> SIREN_HOLD, load ALARM_ON.
  - SIREN_HOLD: ignition -> DIS_IGN. Any door open -> SIREN, which abandons the countdown. expired -> ARMED.
  - DIS_IGN: ignition low -> DIS_WAIT_OPEN.
  - DIS_WAIT_OPEN: ignition -> DIS_IGN. driverDoor -> DIS_WAIT_CLOSE.
  - DIS_WAIT_CLOSE: ignition -> DIS_IGN. driverDoor low -> ARM_DELAY, load ARM_DELAY.
  - ARM_DELAY: ignition -> DIS_IGN. driverDoor -> DIS_WAIT_CLOSE. expired -> ARMED. Passenger doors are ignored.
- Outputs:
  - siren = 1 in SIREN and SIREN_HOLD.
  - statusIndicator = clock1Hz in ARMED, 1 in TRIGGERED, SIREN and SIREN_HOLD, 0 in every DIS_* state and in ARM_DELAY.

## Timing
- All outputs are registered. Reset values:
  - state = ARMED (0)
  - startTimer = 0
  - value = 0
  - siren = 0
  - statusIndicator = 0
- Load action: on the edge that enters a timed state, value takes the selected parameter and startTimer goes to 1. startTimer returns to 0 on the following edge, so it is exactly one cycle wide.
- value holds its last loaded parameter until the next load. It is unchanged by leaving a timed state.
- expired is acted on only when all of the following hold:
  - the FSM is in the timed state that issued the load;
  - startTimer is 0 in that cycle;
  - at least one cycle has passed since the load.
- Any other expired pulse is ignored. This guarantees that a stale expiry from an abandoned countdown is never honoured.
- Re-entering a timed state, for example SIREN -> SIREN_HOLD a second time, issues a fresh load.
- Input-to-output latency: a condition sampled on edge N is reflected in state, siren and startTimer after edge N.
- statusIndicator follows clock1Hz with one cycle of latency.
- reset or reprogram mid-countdown: startTimer stays 0, the FSM goes to ARMED, and any later expired pulse is ignored.
- If a door condition and expired are both true in the same cycle, the door condition wins in SIREN_HOLD and in ARM_DELAY.

## Test plan
- Reset, then hold all inputs 0 for 20 cycles -> state = 0, siren = 0, startTimer never pulses, statusIndicator tracks clock1Hz delayed one cycle.
- In ARMED, pulse driverDoor -> next cycle state = 1, startTimer = 1 for one cycle, value = 8. After expired: state = 2, siren = 1. Close the door -> state = 3, value = 10. After expired: state = 0, siren = 0.
- In ARMED, driverDoor and passengerDoor rise together -> value = 8. passengerDoor alone -> value = 15. Raise ignition before expired -> state = 4, siren = 0, and the later expired pulse is ignored.
- Disarm sequence: ignition off -> state 5. Driver door open -> 6. Door closed -> 7 with value = 6. Reopen before expired -> 6. Close again -> 7 with a fresh load. After expired -> 0.
- Write timeParamSel = 1, timeValue = 3 with a reprogram pulse while in SIREN -> next cycle state = 0, siren = 0, no startTimer. The next driver-door trigger loads value = 3.
- In SIREN_HOLD, assert a door open and expired in the same cycle -> state = 2, siren stays 1.
